// File: rtl/serv_axi_mem_responder_if.sv
// AXI4-Lite style channel bundle between the SERV bridge master and the memory responder.
// No IDs; rlast accompanies every read beat.
interface serv_axi_mem_responder_if #(
    parameter int AW = 13
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/serv_axi_mem_responder.sv
// Single-outstanding AXI4-Lite responder backed by a word RAM with byte strobes.
// Writes win over reads; out-of-range accesses answer SLVERR.
module serv_axi_mem_responder #(
    parameter int    AW      = 13,
    parameter int    MEMSIZE = 8192,
    parameter string MEMFILE = ""
) (
    input logic                     clk,
    input logic                     rst_n,
    serv_axi_mem_responder_if.slave axi
);
    localparam int            DEPTH = MEMSIZE / 4;
    localparam int            IW    = $clog2(DEPTH);
    localparam logic [AW:0]   LIMIT = (AW + 1)'(MEMSIZE);

    typedef enum logic [1:0] {IDLE, WCOLLECT, WRESP, RRESP} state_t;

    state_t        state, state_nx;
    logic          have_aw, have_w;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic [3:0]    strb_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [31:0]   rdata_q;
    logic          commit;
    logic          rd_take;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata_c;
    logic [3:0]    wstrb_c;
    logic          w_ok, r_ok;
    logic [31:0]   mem [DEPTH];

    // A channel captured in WCOLLECT takes precedence over the live bus
    assign waddr   = have_aw ? addr_q : axi.awaddr;
    assign wdata_c = have_w ? data_q : axi.wdata;
    assign wstrb_c = have_w ? strb_q : axi.wstrb;
    assign w_ok    = {1'b0, waddr} < LIMIT;
    assign r_ok    = {1'b0, axi.araddr} < LIMIT;

    always_comb begin
        state_nx    = state;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.arready = 1'b0;
        commit      = 1'b0;
        rd_take     = 1'b0;
        unique case (state)
            IDLE: begin
                axi.awready = 1'b1;
                axi.wready  = 1'b1;
                axi.arready = ~axi.awvalid & ~axi.wvalid;
                if (axi.awvalid & axi.wvalid) begin
                    commit   = 1'b1;
                    state_nx = WRESP;
                end else if (axi.awvalid | axi.wvalid) begin
                    state_nx = WCOLLECT;
                end else if (axi.arvalid) begin
                    rd_take  = 1'b1;
                    state_nx = RRESP;
                end
            end
            WCOLLECT: begin
                axi.awready = ~have_aw;
                axi.wready  = ~have_w;
                if ((~have_aw & axi.awvalid) | (~have_w & axi.wvalid)) begin
                    commit   = 1'b1;
                    state_nx = WRESP;
                end
            end
            WRESP: if (axi.bready) state_nx = IDLE;
            RRESP: if (axi.rready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_aw <= 1'b0;
            have_w  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= 2'b00;
            rresp_q <= 2'b00;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && axi.awvalid && !axi.wvalid) begin
                have_aw <= 1'b1;
                addr_q  <= axi.awaddr;
            end
            if (state == IDLE && axi.wvalid && !axi.awvalid) begin
                have_w <= 1'b1;
                data_q <= axi.wdata;
                strb_q <= axi.wstrb;
            end
            if (commit) begin
                have_aw <= 1'b0;
                have_w  <= 1'b0;
                bresp_q <= w_ok ? 2'b00 : 2'b10;
            end
            if (rd_take) begin
                rdata_q <= r_ok ? mem[axi.araddr[IW+1:2]] : 32'h0;
                rresp_q <= r_ok ? 2'b00 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && w_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_c[i]) mem[waddr[IW+1:2]][8*i +: 8] <= wdata_c[8*i +: 8];
            end
        end
    end

    assign axi.bvalid = (state == WRESP);
    assign axi.bresp  = bresp_q;
    assign axi.rvalid = (state == RRESP);
    assign axi.rlast  = (state == RRESP);
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;
endmodule

// File: tb/tb_serv_axi_mem_responder.sv
// Randomized bench for serv_axi_mem_responder against a word-array memory model.
// MEMSIZE=4096 so that addresses from 0x1000 exercise the error path.
module tb_serv_axi_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serv_axi_mem_responder_if #(.AW(13)) bus ();

    serv_axi_mem_responder #(
        .AW(13),
        .MEMSIZE(4096),
        .MEMFILE("")
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axi(bus.slave)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] ref_mem [1024];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_write(input logic [12:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        if (a >= 13'h1000) return 2'b10;
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [12:0] a);
        return (a >= 13'h1000) ? 32'h0 : ref_mem[a[11:2]];
    endfunction

    // mode 0: AW+W together, 1: W leads AW by gap, 2: AW leads W by gap
    task automatic do_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int gap, input int bstall);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int t = 0;
        logic [1:0] eresp;
        bus.awaddr = a;
        bus.wdata  = d;
        bus.wstrb  = s;
        while (!(aw_done && w_done) && t < 40) begin
            bus.awvalid = !aw_done && (mode != 1 || t >= gap);
            bus.wvalid  = !w_done && (mode != 2 || t >= gap);
            #1;
            check("b_early", bus.bvalid, 0);
            hs_aw = bus.awvalid & bus.awready;
            hs_w  = bus.wvalid & bus.wready;
            @(posedge clk);
            #1;
            aw_done |= hs_aw;
            w_done  |= hs_w;
            t++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("wr_timeout", t < 40, 1);
        eresp = model_write(a, d, s);
        check("bvalid", bus.bvalid, 1);
        check("bresp", bus.bresp, eresp);
        for (int i = 0; i < bstall; i++) begin
            @(posedge clk);
            #1;
            check("b_hold", {bus.bvalid, bus.bresp}, {1'b1, eresp});
            check("b_rdy", {bus.awready, bus.wready, bus.arready}, 0);
        end
        bus.bready = 1'b1;
        @(posedge clk);
        #1;
        bus.bready = 1'b0;
        check("b_done", bus.bvalid, 0);
    endtask

    task automatic do_read(input logic [12:0] a, input int rstall);
        bit hs = 0;
        int t = 0;
        logic [31:0] ed;
        logic [1:0] er;
        ed = model_read(a);
        er = (a >= 13'h1000) ? 2'b10 : 2'b00;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        while (!hs && t < 40) begin
            #1;
            hs = bus.arready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.arvalid = 1'b0;
        check("rd_timeout", hs, 1);
        check("rvalid", bus.rvalid, 1);
        check("rlast", bus.rlast, 1);
        check("rdata", bus.rdata, ed);
        check("rresp", bus.rresp, er);
        for (int i = 0; i < rstall; i++) begin
            @(posedge clk);
            #1;
            check("r_hold", {bus.rvalid, bus.rlast, bus.rresp}, {1'b1, 1'b1, er});
            check("r_hold_d", bus.rdata, ed);
            check("r_rdy", {bus.awready, bus.wready, bus.arready}, 0);
        end
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
        check("r_done", bus.rvalid, 0);
    endtask

    initial begin
        logic [12:0] a;
        logic [31:0] d;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arvalid = 0;
        bus.rready = 0;

        #12;
        check("rst_valid", {bus.bvalid, bus.rvalid, bus.rlast}, 0);
        check("rst_resp", {bus.bresp, bus.rresp}, 0);
        check("rst_rdata", bus.rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 64; i++)
            do_write(13'(i * 4), $urandom, 4'hF, 0, 0, 0);

        do_write(13'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(13'h010, 0);
        do_write(13'h010, 32'h000000AA, 4'h1, 1, 3, 0);
        do_read(13'h010, 0);
        check("split_val", model_read(13'h010), 32'hDEADBEAA);
        do_write(13'h014, 32'h11223344, 4'h0, 2, 2, 1);
        do_read(13'h014, 5);

        // AR competes with a simultaneous AW+W in IDLE
        bus.awaddr = 13'h020; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
        bus.araddr = 13'h020;
        bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
        #1;
        check("prio_ar0", bus.arready, 0);
        @(posedge clk);
        #1;
        bus.awvalid = 0; bus.wvalid = 0;
        void'(model_write(13'h020, 32'hCAFEF00D, 4'hF));
        check("prio_b", bus.bvalid, 1);
        check("prio_ar1", bus.arready, 0);
        bus.bready = 1;
        @(posedge clk);
        #1;
        bus.bready = 0;
        check("prio_ar2", bus.arready, 1);
        @(posedge clk);
        #1;
        bus.arvalid = 0;
        check("prio_rv", bus.rvalid, 1);
        check("prio_rd", bus.rdata, 32'hCAFEF00D);
        bus.rready = 1;
        @(posedge clk);
        #1;
        bus.rready = 0;

        do_write(13'h1000, 32'h12345678, 4'hF, 0, 0, 0);
        do_read(13'h000, 0);
        do_read(13'h1000, 2);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) a = 13'h1000 + 13'(4 * $urandom_range(0, 1023));
            else                           a = 13'(4 * $urandom_range(0, 63));
            a = a | 13'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        // Reset while a read response is stalled
        bus.araddr = 13'h010; bus.arvalid = 1;
        @(posedge clk);
        #1;
        bus.arvalid = 0;
        check("rst_pre", bus.rvalid, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {bus.rvalid, bus.rlast, bus.bvalid}, 0);
        check("rst_rd0", bus.rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_write(13'h030, 32'h5A5AA5A5, 4'hF, 1, 1, 0);
        do_read(13'h030, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
